// File: rtl/data_mem_cipher_arbiter.sv
// data_mem_cipher_arbiter
//   Shares the single data-memory block-cipher core between the read path
//   (decrypt) and the write path (encrypt). Grants one requester at a time,
//   pulses the core start, waits for the core to finish (with a watchdog)
//   and hands a completion level back to the granted requester.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in WAIT before a watchdog abort (>=2)
//   CNT_W           watchdog counter width; must hold TIMEOUT_CYCLES
//
// Ports
//   clk                  in   system clock, all logic on posedge
//   reset                in   synchronous, active-high
//   rd_req / wr_req      in   level requests, held until the matching done
//   rd_grant / wr_grant  out  core owned by that path (START..DONE)
//   rd_done / wr_done    out  result valid, level in DONE for the owner
//   cipher_initializing  in   core key schedule running; blocks new grants
//   cipher_busy          in   core processing; rises the cycle after start
//   cipher_start         out  one-cycle start pulse to the core
//   cipher_mode          out  0 = decrypt, 1 = encrypt; stable START..DONE
//   timeout_err          out  sticky watchdog abort flag, cleared by reset
module data_mem_cipher_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic rd_req,
    input  logic wr_req,
    output logic rd_grant,
    output logic wr_grant,
    output logic rd_done,
    output logic wr_done,
    input  logic cipher_initializing,
    input  logic cipher_busy,
    output logic cipher_start,
    output logic cipher_mode,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    state_t           r_state;
    state_t           w_next_state;
    owner_t           r_owner;
    owner_t           r_last_grant;
    owner_t           w_sel_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic             w_owner_req;
    logic             w_wd_expired;
    logic             w_timeout_hit;

    assign w_owner_req  = (r_owner == OWN_RD) ? rd_req : wr_req;
    assign w_wd_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Round-robin on a tie: the path that was not served last wins.
    always_comb begin
        w_sel_owner = OWN_RD;
        if (rd_req && wr_req) begin
            w_sel_owner = (r_last_grant == OWN_WR) ? OWN_RD : OWN_WR;
        end else if (wr_req) begin
            w_sel_owner = OWN_WR;
        end
    end

    // State register plus the small amount of datapath tied to transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= OWN_RD;
            r_last_grant  <= OWN_WR;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_next_state == S_START) begin
                r_owner <= w_sel_owner;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == S_DONE && w_next_state == S_IDLE) begin
                r_cnt        <= '0;
                r_last_grant <= r_owner;
            end
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Next-state logic. cipher_initializing only gates leaving IDLE.
    always_comb begin
        w_next_state  = S_IDLE;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!cipher_initializing && (rd_req || wr_req)) begin
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: w_next_state = S_WAIT;
            S_WAIT: begin
                if (!cipher_busy) begin
                    w_next_state = S_DONE;
                end else if (w_wd_expired) begin
                    w_next_state  = S_DONE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE: w_next_state = w_owner_req ? S_DONE : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state and owner.
    always_comb begin
        rd_grant     = 1'b0;
        wr_grant     = 1'b0;
        rd_done      = 1'b0;
        wr_done      = 1'b0;
        cipher_start = 1'b0;
        cipher_mode  = 1'b0;
        timeout_err  = r_timeout_err;
        case (r_state)
            S_START, S_WAIT, S_DONE: begin
                rd_grant    = (r_owner == OWN_RD);
                wr_grant    = (r_owner == OWN_WR);
                cipher_mode = (r_owner == OWN_WR);
                if (r_state == S_START) begin
                    cipher_start = 1'b1;
                end
                if (r_state == S_DONE) begin
                    rd_done = (r_owner == OWN_RD);
                    wr_done = (r_owner == OWN_WR);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_mem_cipher_arbiter.sv
module tb_data_mem_cipher_arbiter;

    logic clk;
    logic reset;
    logic rd_req;
    logic wr_req;
    logic rd_grant;
    logic wr_grant;
    logic rd_done;
    logic wr_done;
    logic cipher_initializing;
    logic cipher_busy;
    logic cipher_start;
    logic cipher_mode;
    logic timeout_err;

    data_mem_cipher_arbiter #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .rd_grant(rd_grant),
        .wr_grant(wr_grant),
        .rd_done(rd_done),
        .wr_done(wr_done),
        .cipher_initializing(cipher_initializing),
        .cipher_busy(cipher_busy),
        .cipher_start(cipher_start),
        .cipher_mode(cipher_mode),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher core stand-in: busy rises the cycle after start and stays high
    // for busy_len cycles, or forever while stuck is set.
    int   busy_len;
    logic stuck;
    int   bcnt;
    always @(posedge clk) begin
        if (reset) bcnt <= 0;
        else if (cipher_start) bcnt <= busy_len;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign cipher_busy = stuck | (bcnt != 0);

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic is_rd;
        logic err;
    } exp_t;
    exp_t q[$];

    task automatic push(input logic is_rd, input logic err);
        exp_t e;
        e.is_rd = is_rd;
        e.err   = err;
        q.push_back(e);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each done rising.
    logic prev_done  = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk("done_exclusive", int'(rd_done & wr_done), 0);
        chk("grant_exclusive", int'(rd_grant & wr_grant), 0);
        chk("start_one_cycle", int'(cipher_start & prev_start), 0);
        if ((rd_done | wr_done) && !prev_done) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done got rd=%0d wr=%0d exp none", rd_done, wr_done);
            end else begin
                e = q.pop_front();
                chk("done_owner", int'(rd_done), int'(e.is_rd));
                chk("done_grant", int'(rd_grant), int'(e.is_rd));
                chk("done_mode", int'(cipher_mode), int'(!e.is_rd));
                chk("done_timeout_err", int'(timeout_err), int'(e.err));
            end
        end
        prev_done  = rd_done | wr_done;
        prev_start = cipher_start;
    end

    task automatic wait_done(input logic rd, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((rd ? rd_done : wr_done) || n >= 60) break;
        end
        chk(rd ? "rd_done_seen" : "wr_done_seen", int'(rd ? rd_done : wr_done), 1);
    endtask

    function automatic int all_outs();
        return int'({rd_grant, wr_grant, rd_done, wr_done, cipher_start, cipher_mode, timeout_err});
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        cipher_initializing = 1'b0;
        busy_len = 0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b0;

        // Simultaneous requests: RD first after reset, then alternation.
        busy_len = 2;
        push(1'b1, 1'b0);
        rd_req = 1'b1;
        wr_req = 1'b1;
        wait_done(1'b1, n);
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        chk("idle_after_rr1", int'({rd_grant, wr_grant}), 0);
        push(1'b0, 1'b0);
        push(1'b1, 1'b0);
        rd_req = 1'b1;
        wr_req = 1'b1;
        wait_done(1'b0, n);
        wr_req = 1'b0;
        wait_done(1'b1, n);
        rd_req = 1'b0;
        @(negedge clk);

        // Single read, busy high 5 cycles.
        busy_len = 5;
        push(1'b1, 1'b0);
        rd_req = 1'b1;
        @(negedge clk);
        chk("rd_start", int'({cipher_start, rd_grant, cipher_mode}), 3'b110);
        wait_done(1'b1, n);
        chk("rd_latency", 1 + n, 8);
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_idle_after_drop", int'({rd_grant, rd_done}), 0);

        // Initialization blocks the grant; start one cycle after it falls.
        busy_len = 0;
        cipher_initializing = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("init_blocks", int'({cipher_start, wr_grant, rd_grant}), 0);
        end
        push(1'b0, 1'b0);
        cipher_initializing = 1'b0;
        @(negedge clk);
        chk("start_after_init", int'({cipher_start, wr_grant, cipher_mode}), 3'b111);

        // Done held as a level while req stays high in DONE.
        wait_done(1'b0, n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr_done_level", int'(wr_done), 1);
        end
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_idle_after_drop", int'({wr_done, wr_grant, rd_grant}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_second_start", int'(cipher_start), 0);
        end

        // Owner drops req before DONE: sequence still completes.
        busy_len = 3;
        push(1'b1, 1'b0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        wait_done(1'b1, n);
        @(negedge clk);
        chk("early_drop_idle", int'({rd_done, rd_grant}), 0);

        // Busy stuck high: watchdog abort after 8 WAIT cycles, sticky error.
        stuck = 1'b1;
        push(1'b1, 1'b1);
        rd_req = 1'b1;
        @(negedge clk);
        wait_done(1'b1, n);
        chk("timeout_latency", 1 + n, 10);
        rd_req = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        busy_len = 1;
        push(1'b0, 1'b1);
        wr_req = 1'b1;
        wait_done(1'b0, n);
        wr_req = 1'b0;
        @(negedge clk);
        chk("timeout_sticky", int'(timeout_err), 1);

        // Reset during WAIT, then a normal grant with initializing toggled mid-run.
        busy_len = 5;
        rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_wait_before_reset", int'({rd_grant, cipher_start}), 2'b10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", all_outs(), 0);
        push(1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("start_after_reset", int'({cipher_start, rd_grant}), 2'b11);
        cipher_initializing = 1'b1;
        wait_done(1'b1, n);
        cipher_initializing = 1'b0;
        rd_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
